// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner: FSM states, matrix size
// and the row/column to key-bit mapping.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic {
    IDLE,
    SCAN
  } state_e;

  // Bit position of a key inside the 16-bit frame.
  function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
    return 4'(int'(row) * NUM_COLS + int'(col));
  endfunction

endpackage

// File: rtl/keypad_scanner_col_synchronizer.sv
// Two-flop synchronizer for the active-low keypad column lines; resets to
// the idle (pulled-up) level so no phantom key appears after reset.
module col_synchronizer (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] async_i,
  output logic [3:0] sync_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad matrix scanner: drives one row low at a time, samples the
// synchronized columns after a settle time and publishes whole frames.
// Optional ghost masking is selected with `define KEYPAD_GHOST_MASK_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_en,
  input  logic [3:0]  cols,
  output logic [3:0]  rows,
  output logic [15:0] keys_pressed,
  output logic        frame_valid
);

  localparam logic [15:0] LAST_CNT = 16'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  rowIdx_q, rowIdx_d;
  logic [15:0] settleCnt_q, settleCnt_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] keys_q, keys_d;
  logic [3:0]  rows_q, rows_d;
  logic        frameValid_q, frameValid_d;
  logic [3:0]  colsSync;
  logic [15:0] frame;
  logic [15:0] frameLoad;

  col_synchronizer u_col_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (cols),
    .sync_o  (colsSync)
  );

  // Complete frame as it stands on the row-3 sample edge.
  always_comb begin
    frame = acc_q;
    for (int c = 0; c < NUM_COLS; c++) begin
      frame[key_index(2'd3, 2'(c))] = ~colsSync[c];
    end
  end

`ifdef KEYPAD_GHOST_MASK_EN
  // Three or more keys may include ghosts; report nothing rather than guess.
  assign frameLoad = ($countones(frame) >= 3) ? 16'h0000 : frame;
`else
  assign frameLoad = frame;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rowIdx_q     <= 2'd0;
      settleCnt_q  <= 16'd0;
      acc_q        <= 16'h0000;
      keys_q       <= 16'h0000;
      rows_q       <= 4'b1111;
      frameValid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rowIdx_q     <= rowIdx_d;
      settleCnt_q  <= settleCnt_d;
      acc_q        <= acc_d;
      keys_q       <= keys_d;
      rows_q       <= rows_d;
      frameValid_q <= frameValid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rowIdx_d     = rowIdx_q;
    settleCnt_d  = settleCnt_q;
    acc_d        = acc_q;
    keys_d       = keys_q;
    rows_d       = 4'b1111;
    frameValid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        rowIdx_d    = 2'd0;
        settleCnt_d = 16'd0;
        acc_d       = 16'h0000;
        if (scan_en) begin
          state_d = SCAN;
          rows_d  = 4'b1110;
        end
      end
      SCAN: begin
        if (!scan_en) begin
          // Abort drops the partial frame; keys_pressed keeps the last full one.
          state_d     = IDLE;
          rowIdx_d    = 2'd0;
          settleCnt_d = 16'd0;
          acc_d       = 16'h0000;
        end else begin
          if (settleCnt_q == LAST_CNT) begin
            settleCnt_d = 16'd0;
            rowIdx_d    = rowIdx_q + 2'd1;
            if (rowIdx_q == 2'd3) begin
              keys_d       = frameLoad;
              acc_d        = 16'h0000;
              frameValid_d = 1'b1;
            end else begin
              for (int c = 0; c < NUM_COLS; c++) begin
                acc_d[key_index(rowIdx_q, 2'(c))] = ~colsSync[c];
              end
            end
          end else begin
            settleCnt_d = settleCnt_q + 16'd1;
          end
          rows_d = ~(4'b0001 << rowIdx_d);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rows         = rows_q;
  assign keys_pressed = keys_q;
  assign frame_valid  = frameValid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (SETTLE_CYCLES=8): a keypad matrix
// model answers the row drive, and expected frames come from the held keys.
module tb_keypad_scanner;

  localparam int SETTLE = 8;
  localparam int FRAME  = 4 * SETTLE;

  logic        clk;
  logic        reset;
  logic        scan_en;
  logic [3:0]  cols;
  logic [3:0]  rows;
  logic [15:0] keys_pressed;
  logic        frame_valid;

  logic [15:0] held;
  int          nVec;
  int          nMis;

  keypad_scanner #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk          (clk),
    .reset        (reset),
    .scan_en      (scan_en),
    .cols         (cols),
    .rows         (rows),
    .keys_pressed (keys_pressed),
    .frame_valid  (frame_valid)
  );

  always #5 clk = ~clk;

  // Passive matrix: a held key pulls its column low while its row is driven low.
  always_comb begin
    cols = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!rows[r] && held[r*4+c]) cols[c] = 1'b0;
      end
    end
  end

  function automatic logic [15:0] expFrame(input logic [15:0] h);
`ifdef KEYPAD_GHOST_MASK_EN
    if ($countones(h) >= 3) return 16'h0000;
`endif
    return h;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp)
    else begin
      nMis++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts negedges until frame_valid is seen, then checks latency and frame.
  task automatic applyStimulus(input logic [15:0] expKeys, input int expCycles, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_valid && n < 4 * FRAME);
    checkOutput({tag, "_latency"}, n, expCycles);
    checkOutput({tag, "_keys"}, keys_pressed, expKeys);
  endtask

  task automatic waitRow(input logic [3:0] r, input string tag);
    int n;
    n = 0;
    while (rows !== r && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, rows, r);
  endtask

  initial begin
    int fvSeen;
    int k;
    nVec    = 0;
    nMis    = 0;
    clk     = 1'b0;
    reset   = 1'b0;
    scan_en = 1'b0;
    held    = 16'h0000;

    #12;
    checkOutput("reset_rows", rows, 4'b1111);
    checkOutput("reset_keys", keys_pressed, 16'h0000);
    checkOutput("reset_fv", frame_valid, 1'b0);

    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("idle_rows", rows, 4'b1111);
    checkOutput("idle_fv", frame_valid, 1'b0);

    // First frame after entering SCAN, no keys.
    scan_en = 1'b1;
    @(negedge clk);
    checkOutput("enter_rows", rows, 4'b1110);
    applyStimulus(16'h0000, FRAME, "first_frame");
    applyStimulus(16'h0000, FRAME, "second_frame");

    // Single key row1/col2, then release.
    held = 16'h0040;
    applyStimulus(16'h0040, FRAME, "key_r1c2");
    held = 16'h0000;
    applyStimulus(16'h0000, FRAME, "key_release");

    // Three keys (ghost candidate) and two keys.
    held = 16'h0013;
    applyStimulus(expFrame(16'h0013), FRAME, "three_keys");
    held = 16'h0003;
    applyStimulus(expFrame(16'h0003), FRAME, "two_keys");

    // Random key patterns, one per frame.
    for (int i = 0; i < 10; i++) begin
      held = 16'h0000;
      k = int'($urandom_range(4, 0));
      for (int j = 0; j < k; j++) held[$urandom_range(15, 0)] = 1'b1;
      applyStimulus(expFrame(held), FRAME, $sformatf("rand%0d", i));
    end

    // Abort mid-frame while row 2 is driven.
    held = 16'h0100;
    applyStimulus(16'h0100, FRAME, "pre_abort");
    held = 16'h0200;
    waitRow(4'b1011, "abort_row2");
    scan_en = 1'b0;
    @(negedge clk);
    checkOutput("abort_rows", rows, 4'b1111);
    fvSeen = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (frame_valid) fvSeen++;
    end
    checkOutput("abort_no_fv", fvSeen, 0);
    checkOutput("abort_keys_held", keys_pressed, 16'h0100);
    scan_en = 1'b1;
    @(negedge clk);
    checkOutput("reenable_rows", rows, 4'b1110);
    applyStimulus(16'h0200, FRAME, "after_abort");

    // Asynchronous reset while row 2 is driven.
    held = 16'h8000;
    applyStimulus(16'h8000, FRAME, "pre_reset");
    waitRow(4'b1011, "reset_row2");
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_rows", rows, 4'b1111);
    checkOutput("async_keys", keys_pressed, 16'h0000);
    checkOutput("async_fv", frame_valid, 1'b0);
    fvSeen = 0;
    repeat (3) begin
      @(negedge clk);
      if (frame_valid || rows !== 4'b1111) fvSeen++;
    end
    checkOutput("held_in_reset", fvSeen, 0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("resume_rows", rows, 4'b1110);
    applyStimulus(16'h8000, FRAME, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SETTLE_CYCLES, default 64, number of clock cycles each row is driven before its columns are sampled; legal range 4..65535.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 scan_en  input  1  high to run continuous scanning; low to idle.
REQ-005 cols  input  4  keypad column lines, active-low (pulled up), asynchronous to clk.
REQ-006 rows  output  4  keypad row drive, active-low, registered.
REQ-007 keys_pressed  output  16  last complete frame; bit row*4+col high = key down.
REQ-008 frame_valid  output  1  one-cycle pulse on each keys_pressed update.

Function
REQ-009 The block SHALL pass cols through a two-flop synchronizer before any use, and no other logic SHALL sample raw cols.
REQ-010 The FSM SHALL have states IDLE and SCAN: IDLE->SCAN on scan_en=1; SCAN->IDLE on scan_en=0 at any point.
REQ-011 In IDLE: rows=4'b1111, row index=0, settle counter=0, accumulator cleared, keys_pressed held, frame_valid=0.
REQ-012 In SCAN: rows SHALL equal ~(1<<row index), exactly one row low; rows SHALL become 4'b1110 on the IDLE->SCAN edge.
REQ-013 The settle counter SHALL count 0..SETTLE_CYCLES-1 per row and wrap to 0; at wrap the row index SHALL advance 0->1->2->3->0.
REQ-014 On the edge where counter==SETTLE_CYCLES-1, the synchronized ~cols SHALL be written to accumulator bits [r*4+3:r*4] for current row r.
REQ-015 On the row-3 sample edge, keys_pressed SHALL load the full frame, including the row-3 nibble sampled on that edge.
REQ-016 frame_valid SHALL be high for exactly the one cycle following that edge; frame period = 4*SETTLE_CYCLES cycles.
REQ-017 The accumulator SHALL clear after each frame load, so that a released key reads 0 in the next frame.
REQ-018 An abort (scan_en low mid-frame) SHALL discard the partial frame: no frame_valid, keys_pressed unchanged.
REQ-019 On re-enable, scanning SHALL restart at row 0.
REQ-020 With scan_en rising, the first frame_valid SHALL occur 4*SETTLE_CYCLES cycles after the IDLE->SCAN edge.
REQ-021 Multiple simultaneous keys SHALL all be reported unfiltered, except as specified in REQ-026.

Reset
REQ-022 On reset=0, asynchronously: state=IDLE, rows=4'b1111, keys_pressed=0, frame_valid=0, counter=0, row index=0, accumulator=0, synchronizer flops=4'b1111.
REQ-023 Reset asserted mid-frame SHALL produce no frame_valid; scanning SHALL resume from row 0 only after reset is released and scan_en=1.

Configuration
REQ-024 Macro KEYPAD_GHOST_MASK_EN SHALL select the ghost-masking feature at compile time.
REQ-025 Without the macro: the completed frame SHALL be loaded into keys_pressed as-is.
REQ-026 With the macro: if the completed frame has 3 or more bits set, keys_pressed SHALL load 16'h0000 instead; frame_valid timing SHALL be unchanged.

Structure
REQ-027 Package keypad_pkg SHALL hold: the state enum (IDLE, SCAN), NUM_ROWS=4, NUM_COLS=4, and the key index function row*NUM_COLS+col.
REQ-028 The two-flop column synchronizer SHALL be a sub-module named col_synchronizer, 4 bits wide, with reset value 4'b1111.
REQ-029 The downstream debouncer SHALL consume keys_pressed directly; no other glue is required.

Verification (SETTLE_CYCLES=8)
REQ-030 Reset during SCAN with row 2 driven -> rows=4'b1111, keys_pressed=16'h0000, frame_valid=0 immediately, without waiting for a clock edge.
REQ-031 No keys pressed, scan_en=1 -> frame_valid pulses every 32 cycles; first pulse 32 cycles after entering SCAN; keys_pressed=16'h0000.
REQ-032 Key row1/col2 modelled (cols=4'b1011 while rows=4'b1101) -> keys_pressed=16'h0040 at next frame_valid; after release, 16'h0000 one frame later.
REQ-033 scan_en dropped while row 2 driven -> rows=4'b1111 next cycle, no frame_valid, keys_pressed held; re-enable -> rows=4'b1110, frame_valid 32 cycles later.
REQ-034 Keys 0, 1 and 4 held -> keys_pressed=16'h0013 without KEYPAD_GHOST_MASK_EN; 16'h0000 with it; two keys (0, 1) -> 16'h0003 in both builds.
